pll_lock_sequencer: RTL and testbench

//   Sequences the fabric PLL: holds PLL reset, waits for lock, debounces lock, then releases a

---
 rtl/pll_lock_sequencer.sv | 157 +++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer on the free-running refclk.
// Holds PLL reset, debounces lock, releases system reset, retries/faults.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int RETRY_W       = $clog2(MAX_RETRIES + 1)
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               restart,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               ready,
  output logic               fault,
  output logic [2:0]         state,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [7:0]         loss_cnt
);

  localparam logic [2:0] S_RST    = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STABLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(STABLE_CYCLES + 1);

  localparam logic [RW-1:0] R_LAST = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] S_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] R_MAX = RETRY_W'(MAX_RETRIES);

  logic               lk_meta;
  logic               lk_s;
  logic [RW-1:0]      rcnt, rcnt_n;
  logic [TW-1:0]      tcnt, tcnt_n;
  logic [SW-1:0]      scnt, scnt_n;
  logic [2:0]         nxt;
  logic [RETRY_W-1:0] retry_n;
  logic [7:0]         loss_n;
  logic               timeout;

  // Two-flop synchronizer for the asynchronous lock indication
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      lk_meta <= pll_locked;
      lk_s    <= lk_meta;
    end
  end

  assign timeout = (tcnt == T_LAST);

  // Next-state and counter update; restart overrides everything
  always_comb begin
    nxt     = state;
    rcnt_n  = rcnt;
    tcnt_n  = tcnt;
    scnt_n  = scnt;
    retry_n = retry_cnt;
    loss_n  = loss_cnt;
    if (restart) begin
      nxt     = S_RST;
      rcnt_n  = '0;
      retry_n = '0;
    end else begin
      case (state)
        S_RST: begin
          if (rcnt == R_LAST) begin
            nxt    = S_WAIT;
            rcnt_n = '0;
            tcnt_n = '0;
            scnt_n = '0;
          end else begin
            rcnt_n = rcnt + 1'b1;
          end
        end
        S_WAIT, S_STABLE: begin
          if (timeout) begin
            if (retry_cnt == R_MAX) begin
              nxt = S_FAULT;
            end else begin
              nxt     = S_RST;
              rcnt_n  = '0;
              retry_n = retry_cnt + 1'b1;
            end
          end else begin
            tcnt_n = tcnt + 1'b1;
            if (state == S_WAIT) begin
              if (lk_s) begin
                nxt    = S_STABLE;
                scnt_n = '0;
              end
            end else if (!lk_s) begin
              nxt    = S_WAIT;
              scnt_n = '0;
            end else if (scnt == S_LAST) begin
              nxt     = S_RUN;
              retry_n = '0;
            end else begin
              scnt_n = scnt + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!lk_s) begin
            nxt    = S_RST;
            rcnt_n = '0;
            if (loss_cnt != 8'hff) loss_n = loss_cnt + 8'd1;
          end
        end
        S_FAULT: begin
          nxt = S_FAULT;
        end
        default: begin
          nxt    = S_RST;
          rcnt_n = '0;
        end
      endcase
    end
  end

  // State, counters and outputs registered from the next state
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RST;
      rcnt      <= '0;
      tcnt      <= '0;
      scnt      <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= nxt;
      rcnt      <= rcnt_n;
      tcnt      <= tcnt_n;
      scnt      <= scnt_n;
      retry_cnt <= retry_n;
      loss_cnt  <= loss_n;
      pll_rst   <= (nxt == S_RST) || (nxt == S_FAULT);
      sys_rst_n <= (nxt == S_RUN);
      ready     <= (nxt == S_RUN);
      fault     <= (nxt == S_FAULT);
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer.
// Small parameters keep timeout/fault sequences short.
module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst, sys_rst_n, ready, fault;
  logic [2:0] state;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  pll_lock_sequencer #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(100),
    .STABLE_CYCLES(8), .MAX_RETRIES(2)
  ) dut (
    .refclk(clk), .rst_n(rst_n),
    .pll_locked(pll_locked), .restart(restart),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n),
    .ready(ready), .fault(fault), .state(state),
    .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Reset is released 1 time unit after an edge; next edge is cycle 1
  task automatic apply_reset();
    restart = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({state, pll_rst, sys_rst_n, ready, fault} !== {3'd0, 4'b1000}) begin
      n_bad++;
      $display("FAIL reset_outs got st=%0d pr=%b sr=%b rd=%b f=%b want 0 1 0 0 0",
               state, pll_rst, sys_rst_n, ready, fault);
    end
    n_cmp++;
    if ({retry_cnt, loss_cnt} !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_cnts got r=%0d l=%0d want 0 0", retry_cnt, loss_cnt);
    end
    tick();
    n_cmp++;
    if (state !== 3'd0 || pll_rst !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_held got st=%0d pr=%b want 0 1", state, pll_rst);
    end
  endtask

  task automatic test_nominal();
    pll_locked = 1'b0;
    apply_reset();
    n_cmp++;
    if (pll_rst !== 1'b1) begin
      n_bad++;
      $display("FAIL nom_prst_c0 got %b want 1", pll_rst);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++;
      if (pll_rst !== 1'b1 || state !== 3'd0) begin
        n_bad++;
        $display("FAIL nom_prst_c%0d got pr=%b st=%0d want 1 0", i, pll_rst, state);
      end
    end
    tick();
    n_cmp++;
    if (pll_rst !== 1'b0 || state !== 3'd1) begin
      n_bad++;
      $display("FAIL nom_wait got pr=%b st=%0d want 0 1", pll_rst, state);
    end
    ticks(2);
    pll_locked = 1'b1;
    ticks(10);
    n_cmp++;
    if (state !== 3'd2 || sys_rst_n !== 1'b0) begin
      n_bad++;
      $display("FAIL nom_early got st=%0d sr=%b want 2 0", state, sys_rst_n);
    end
    tick();
    n_cmp++;
    if ({state, sys_rst_n, ready, pll_rst} !== {3'd3, 3'b110}) begin
      n_bad++;
      $display("FAIL nom_run got st=%0d sr=%b rd=%b pr=%b want 3 1 1 0",
               state, sys_rst_n, ready, pll_rst);
    end
    n_cmp++;
    if (retry_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL nom_retry got %0d want 0", retry_cnt);
    end
  endtask

  task automatic test_lock_loss();
    int w;
    pll_locked = 1'b0;
    ticks(2);
    n_cmp++;
    if (state !== 3'd3 || ready !== 1'b1) begin
      n_bad++;
      $display("FAIL loss_lag got st=%0d rd=%b want 3 1", state, ready);
    end
    tick();
    n_cmp++;
    if ({state, sys_rst_n, ready, pll_rst} !== {3'd0, 3'b001}) begin
      n_bad++;
      $display("FAIL loss_drop got st=%0d sr=%b rd=%b pr=%b want 0 0 0 1",
               state, sys_rst_n, ready, pll_rst);
    end
    n_cmp++;
    if (loss_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL loss_cnt1 got %0d want 1", loss_cnt);
    end
    for (int k = 0; k < 300; k++) begin
      pll_locked = 1'b1;
      w = 0;
      while (state !== 3'd3 && w < 100) begin
        tick();
        w++;
      end
      if (w >= 100) begin
        n_cmp++;
        n_bad++;
        $display("FAIL loss_loop_run k=%0d st=%0d want 3", k, state);
      end
      pll_locked = 1'b0;
      w = 0;
      while (state !== 3'd0 && w < 10) begin
        tick();
        w++;
      end
      if (w >= 10) begin
        n_cmp++;
        n_bad++;
        $display("FAIL loss_loop_rst k=%0d st=%0d want 0", k, state);
      end
      if (k == 252) begin
        n_cmp++;
        if (loss_cnt !== 8'd254) begin
          n_bad++;
          $display("FAIL loss_cnt254 got %0d want 254", loss_cnt);
        end
      end
    end
    n_cmp++;
    if (loss_cnt !== 8'd255) begin
      n_bad++;
      $display("FAIL loss_sat got %0d want 255", loss_cnt);
    end
  endtask

  task automatic test_restart_run();
    int w;
    pll_locked = 1'b1;
    w = 0;
    while (state !== 3'd3 && w < 100) begin
      tick();
      w++;
    end
    n_cmp++;
    if (state !== 3'd3) begin
      n_bad++;
      $display("FAIL rr_reach got st=%0d want 3", state);
    end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    n_cmp++;
    if ({state, ready, pll_rst, retry_cnt} !== {3'd0, 2'b01, 2'd0}) begin
      n_bad++;
      $display("FAIL rr_state got st=%0d rd=%b pr=%b r=%0d want 0 0 1 0",
               state, ready, pll_rst, retry_cnt);
    end
    n_cmp++;
    if (loss_cnt !== 8'd255) begin
      n_bad++;
      $display("FAIL rr_loss_kept got %0d want 255", loss_cnt);
    end
  endtask

  task automatic test_glitch();
    pll_locked = 1'b0;
    apply_reset();
    ticks(4);
    pll_locked = 1'b1;
    ticks(5);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    n_cmp++;
    if (state !== 3'd2) begin
      n_bad++;
      $display("FAIL gl_stable got st=%0d want 2", state);
    end
    tick();
    n_cmp++;
    if (state !== 3'd1) begin
      n_bad++;
      $display("FAIL gl_back_wait got st=%0d want 1", state);
    end
    tick();
    ticks(7);
    n_cmp++;
    if (state !== 3'd2 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL gl_not_yet got st=%0d rd=%b want 2 0", state, ready);
    end
    tick();
    n_cmp++;
    if (state !== 3'd3 || retry_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL gl_run got st=%0d r=%0d want 3 0", state, retry_cnt);
    end
  endtask

  task automatic test_timeout_fault();
    pll_locked = 1'b0;
    apply_reset();
    for (int a = 0; a < 3; a++) begin
      ticks(103);
      n_cmp++;
      if (state !== 3'd1 || retry_cnt !== 2'(a)) begin
        n_bad++;
        $display("FAIL to_wait%0d got st=%0d r=%0d want 1 %0d", a, state, retry_cnt, a);
      end
      tick();
      if (a < 2) begin
        n_cmp++;
        if (state !== 3'd0 || retry_cnt !== 2'(a + 1) || pll_rst !== 1'b1) begin
          n_bad++;
          $display("FAIL to_retry%0d got st=%0d r=%0d pr=%b want 0 %0d 1",
                   a, state, retry_cnt, pll_rst, a + 1);
        end
      end
    end
    n_cmp++;
    if ({state, fault, pll_rst, sys_rst_n, ready} !== {3'd4, 4'b1100}) begin
      n_bad++;
      $display("FAIL to_fault got st=%0d f=%b pr=%b sr=%b rd=%b want 4 1 1 0 0",
               state, fault, pll_rst, sys_rst_n, ready);
    end
    ticks(500);
    pll_locked = 1'b1;
    ticks(500);
    n_cmp++;
    if ({state, fault, pll_rst, sys_rst_n} !== {3'd4, 3'b110}) begin
      n_bad++;
      $display("FAIL to_sticky got st=%0d f=%b pr=%b sr=%b want 4 1 1 0",
               state, fault, pll_rst, sys_rst_n);
    end
  endtask

  task automatic test_restart_fault();
    int w;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    n_cmp++;
    if ({state, fault, pll_rst, retry_cnt} !== {3'd0, 2'b01, 2'd0}) begin
      n_bad++;
      $display("FAIL rf_state got st=%0d f=%b pr=%b r=%0d want 0 0 1 0",
               state, fault, pll_rst, retry_cnt);
    end
    w = 0;
    while (state !== 3'd3 && w < 200) begin
      tick();
      w++;
    end
    n_cmp++;
    if (state !== 3'd3 || ready !== 1'b1 || retry_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL rf_run got st=%0d rd=%b r=%0d want 3 1 0", state, ready, retry_cnt);
    end
  endtask

  task automatic test_restart_held();
    restart = 1'b1;
    ticks(10);
    n_cmp++;
    if (state !== 3'd0 || pll_rst !== 1'b1) begin
      n_bad++;
      $display("FAIL rh_hold got st=%0d pr=%b want 0 1", state, pll_rst);
    end
    restart = 1'b0;
    ticks(3);
    n_cmp++;
    if (state !== 3'd0) begin
      n_bad++;
      $display("FAIL rh_cnt3 got st=%0d want 0", state);
    end
    tick();
    n_cmp++;
    if (state !== 3'd1) begin
      n_bad++;
      $display("FAIL rh_cnt4 got st=%0d want 1", state);
    end
  endtask

  task automatic test_async_reset();
    int w;
    w = 0;
    while (state !== 3'd3 && w < 100) begin
      tick();
      w++;
    end
    pll_locked = 1'b0;
    ticks(3);
    pll_locked = 1'b1;
    w = 0;
    while (state !== 3'd2 && w < 100) begin
      tick();
      w++;
    end
    n_cmp++;
    if (state !== 3'd2 || loss_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL ar_setup got st=%0d l=%0d want 2 1", state, loss_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({state, pll_rst, sys_rst_n, ready, fault} !== {3'd0, 4'b1000}) begin
      n_bad++;
      $display("FAIL ar_outs got st=%0d pr=%b sr=%b rd=%b f=%b want 0 1 0 0 0",
               state, pll_rst, sys_rst_n, ready, fault);
    end
    n_cmp++;
    if ({retry_cnt, loss_cnt} !== 10'd0) begin
      n_bad++;
      $display("FAIL ar_cnts got r=%0d l=%0d want 0 0", retry_cnt, loss_cnt);
    end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lock_loss();
    test_restart_run();
    test_glitch();
    test_timeout_fault();
    test_restart_fault();
    test_restart_held();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
